// File: rtl/ay8_bus_master.sv
// ay8_bus_master: upstream master for the multiplexed uniBus feeding the Memory block.
// One request is taken at a time over a valid/ready handshake.
// Each request runs a bus cycle in this order:
//   - an address phase with ALE,
//   - a turnaround cycle, for reads only,
//   - a data phase with an RD or WR strobe.
// Completion is signalled by a one-cycle rsp_valid pulse.
//
// Handshake: a request transfers on any posedge where req_valid && req_ready.
// req_ready is high only in IDLE, which includes the response cycle, so
// back-to-back requests need no gap. The requester holds req_* stable while
// req_valid is high and not yet accepted. Request inputs are ignored while busy.
module ay8_bus_master #(
  parameter int DATA_W      = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  inout  wire  [DATA_W-1:0] uniBus,
  output logic              bus_ale,
  output logic              bus_rd,
  output logic              bus_wr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_TURN = 2'd2,
    S_DATA = 2'd3
  } state_e;

  localparam logic [3:0] WAIT_LOAD = WAIT_STATES[3:0];

  state_e              state_q, state_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [3:0]          wait_q, wait_d;
  logic                req_ready_q, req_ready_d;
  logic                busy_q, busy_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                bus_ale_q, bus_ale_d;
  logic                bus_rd_q, bus_rd_d;
  logic                bus_wr_q, bus_wr_d;
  logic                bus_drive;

  // Next-state and next-output logic; outputs are derived from the next state so they are registered.
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wait_d      = wait_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        // Writes go straight to data; reads need a cycle for the bus to change hands.
        if (write_q) begin
          state_d = S_DATA;
          wait_d  = WAIT_LOAD;
        end else begin
          state_d = S_TURN;
        end
      end
      S_TURN: begin
        state_d = S_DATA;
        wait_d  = WAIT_LOAD;
      end
      S_DATA: begin
        if (wait_q == 4'd0) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_write_d = write_q;
          // The Memory drives uniBus during a read DATA cycle; capture it as-is.
          if (!write_q) rsp_rdata_d = uniBus;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    bus_ale_d   = (state_d == S_ADDR);
    bus_rd_d    = (state_d == S_DATA) && !write_d;
    bus_wr_d    = (state_d == S_DATA) && write_d;
  end

  // State and registered outputs; reset aborts any bus cycle immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wait_q      <= 4'd0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      bus_ale_q   <= 1'b0;
      bus_rd_q    <= 1'b0;
      bus_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wait_q      <= wait_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      bus_ale_q   <= bus_ale_d;
      bus_rd_q    <= bus_rd_d;
      bus_wr_q    <= bus_wr_d;
    end
  end

  // Bus drive comes only from the state register, so reset releases it in the same cycle.
  assign bus_drive = (state_q == S_ADDR) || ((state_q == S_DATA) && write_q);
  assign uniBus    = bus_drive ? ((state_q == S_ADDR) ? addr_q : wdata_q) : {DATA_W{1'bz}};

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign bus_ale   = bus_ale_q;
  assign bus_rd    = bus_rd_q;
  assign bus_wr    = bus_wr_q;

endmodule

// File: tb/tb_ay8_bus_master.sv
// tb_ay8_bus_master: directed bench for ay8_bus_master.
// Two instances are used: one with WAIT_STATES=0 and one with WAIT_STATES=3.
// Each bus is a tri1 net, so a released bus reads 8'hff.
// A small memory model answers RD strobes and stores data on WR strobes.
module tb_ay8_bus_master;

  logic       CLK;
  logic       RST;

  // Instance with WAIT_STATES=0.
  logic       req_valid, req_ready, req_write;
  logic [7:0] req_addr, req_wdata;
  logic       rsp_valid, rsp_write, busy;
  logic [7:0] rsp_rdata;
  logic       bus_ale, bus_rd, bus_wr;
  tri1  [7:0] uni_bus;

  // Instance with WAIT_STATES=3.
  logic       w3_valid, w3_ready, w3_write;
  logic [7:0] w3_addr, w3_wdata;
  logic       w3_rsp_valid, w3_rsp_write, w3_busy;
  logic [7:0] w3_rdata;
  logic       w3_ale, w3_rd, w3_wr;
  tri1  [7:0] w3_bus;

  logic [7:0] mem [256];
  logic [7:0] addr_lat, w3_addr_lat;

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 0;

  ay8_bus_master #(.DATA_W(8), .WAIT_STATES(0)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .busy(busy), .uniBus(uni_bus),
    .bus_ale(bus_ale), .bus_rd(bus_rd), .bus_wr(bus_wr)
  );

  ay8_bus_master #(.DATA_W(8), .WAIT_STATES(3)) dut_w3 (
    .CLK(CLK), .RST(RST),
    .req_valid(w3_valid), .req_ready(w3_ready), .req_write(w3_write),
    .req_addr(w3_addr), .req_wdata(w3_wdata),
    .rsp_valid(w3_rsp_valid), .rsp_write(w3_rsp_write), .rsp_rdata(w3_rdata),
    .busy(w3_busy), .uniBus(w3_bus),
    .bus_ale(w3_ale), .bus_rd(w3_rd), .bus_wr(w3_wr)
  );

  // Memory model: latch the address on ALE, store on WR, drive read data while RD is high.
  always @(posedge CLK) begin
    if (bus_ale) addr_lat <= uni_bus;
    if (bus_wr)  mem[addr_lat] <= uni_bus;
    if (w3_ale)  w3_addr_lat <= w3_bus;
  end
  assign uni_bus = bus_rd ? mem[addr_lat]    : 8'hzz;
  assign w3_bus  = w3_rd  ? mem[w3_addr_lat] : 8'hzz;

  // Clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present one request for one accept edge; returns in cycle c1.
  task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d);
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  // Mid-cycle bus ownership checks on both instances.
  always @(negedge CLK) begin
    if (mon_en) begin
      chk("one_strobe", 32'($countones({bus_ale, bus_rd, bus_wr}) <= 1), 32'd1);
      chk("busy_vs_ready", busy, !req_ready);
      if (!bus_ale && !bus_wr && !bus_rd) chk("bus_released", uni_bus, 8'hff);
      chk("w3_one_strobe", 32'($countones({w3_ale, w3_rd, w3_wr}) <= 1), 32'd1);
      chk("w3_busy_vs_ready", w3_busy, !w3_ready);
      if (!w3_ale && !w3_wr && !w3_rd) chk("w3_bus_released", w3_bus, 8'hff);
    end
  end

  initial begin
    RST = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    w3_valid  = 1'b0; w3_write  = 1'b0; w3_addr  = 8'h00; w3_wdata  = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h01] = 8'h11;
    mem[8'h03] = 8'h13;

    // Reset state
    tick();
    tick();
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_write", rsp_write, 1'b0);
    chk("rst_rdata", rsp_rdata, 8'h00);
    chk("rst_strobes", {bus_ale, bus_rd, bus_wr}, 3'b000);
    chk("rst_bus", uni_bus, 8'hff);
    RST = 1'b0;
    tick();

    // 1: reset during write DATA aborts the cycle
    issue(1'b1, 8'h10, 8'h55);
    tick();
    chk("t1_wr_before", bus_wr, 1'b1);
    chk("t1_bus_before", uni_bus, 8'h55);
    #2 RST = 1'b1;
    #1;
    chk("t1_bus_rel", uni_bus, 8'hff);
    chk("t1_wr", bus_wr, 1'b0);
    chk("t1_busy", busy, 1'b0);
    chk("t1_ready", req_ready, 1'b1);
    #1 RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_no_rsp", rsp_valid, 1'b0);
      chk("t1_idle", busy, 1'b0);
    end

    mon_en = 1'b1;

    // 2: read addr 01, W=0
    issue(1'b0, 8'h01, 8'h00);
    chk("t2_c1_ale", bus_ale, 1'b1);
    chk("t2_c1_bus", uni_bus, 8'h01);
    chk("t2_c1_ready", req_ready, 1'b0);
    tick();
    chk("t2_c2_bus", uni_bus, 8'hff);
    chk("t2_c2_strobes", {bus_ale, bus_rd, bus_wr}, 3'b000);
    tick();
    chk("t2_c3_rd", bus_rd, 1'b1);
    chk("t2_c3_rsp", rsp_valid, 1'b0);
    tick();
    chk("t2_c4_rsp", rsp_valid, 1'b1);
    chk("t2_c4_rdata", rsp_rdata, 8'h11);
    chk("t2_c4_rwrite", rsp_write, 1'b0);
    chk("t2_c4_ready", req_ready, 1'b1);
    tick();
    chk("t2_c5_rsp", rsp_valid, 1'b0);
    chk("t2_c5_rdata_hold", rsp_rdata, 8'h11);

    // 3: write aa to ff, then read it back
    issue(1'b1, 8'hff, 8'haa);
    chk("t3_c1_ale", bus_ale, 1'b1);
    tick();
    chk("t3_c2_wr", bus_wr, 1'b1);
    chk("t3_c2_bus", uni_bus, 8'haa);
    tick();
    chk("t3_c3_wr", bus_wr, 1'b0);
    chk("t3_c3_rsp", rsp_valid, 1'b1);
    chk("t3_c3_rwrite", rsp_write, 1'b1);
    chk("t3_c3_rdata_kept", rsp_rdata, 8'h11);
    issue(1'b0, 8'hff, 8'h00);
    tick();
    tick();
    tick();
    chk("t3_rd_rsp", rsp_valid, 1'b1);
    chk("t3_rd_rdata", rsp_rdata, 8'haa);
    chk("t3_rd_rwrite", rsp_write, 1'b0);

    // 4: back-to-back writes with req_valid held
    req_write = 1'b1; req_addr = 8'hfe; req_wdata = 8'hab; req_valid = 1'b1;
    tick();
    req_addr = 8'hfd; req_wdata = 8'hac;
    chk("t4_a_ale_bus", uni_bus, 8'hfe);
    tick();
    chk("t4_a_wr_bus", uni_bus, 8'hab);
    tick();
    chk("t4_a_rsp", rsp_valid, 1'b1);
    chk("t4_a_ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    chk("t4_b_ale", bus_ale, 1'b1);
    chk("t4_b_ale_bus", uni_bus, 8'hfd);
    chk("t4_b_rsp_off", rsp_valid, 1'b0);
    tick();
    chk("t4_b_wr_bus", uni_bus, 8'hac);
    tick();
    chk("t4_b_rsp", rsp_valid, 1'b1);
    tick();
    chk("t4_mem_fe", mem[8'hfe], 8'hab);
    chk("t4_mem_fd", mem[8'hfd], 8'hac);

    // 5: WAIT_STATES=3 read addr 03
    w3_write = 1'b0; w3_addr = 8'h03; w3_valid = 1'b1;
    tick();
    w3_valid = 1'b0;
    chk("t5_c1_ale", w3_ale, 1'b1);
    chk("t5_c1_bus", w3_bus, 8'h03);
    chk("t5_c1_ready", w3_ready, 1'b0);
    tick();
    chk("t5_c2_rd", w3_rd, 1'b0);
    chk("t5_c2_ready", w3_ready, 1'b0);
    for (int c = 3; c <= 6; c++) begin
      tick();
      chk($sformatf("t5_c%0d_rd", c), w3_rd, 1'b1);
      chk($sformatf("t5_c%0d_ready", c), w3_ready, 1'b0);
      chk($sformatf("t5_c%0d_rsp", c), w3_rsp_valid, 1'b0);
    end
    tick();
    chk("t5_c7_rsp", w3_rsp_valid, 1'b1);
    chk("t5_c7_rdata", w3_rdata, 8'h13);
    chk("t5_c7_rd", w3_rd, 1'b0);
    chk("t5_c7_ready", w3_ready, 1'b1);
    tick();
    chk("t5_c8_rsp", w3_rsp_valid, 1'b0);

    mon_en = 1'b0;
    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
